// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
//
// Collects two operands and an opcode from a switch bus, one per press of a
// load button. It then presents them, registered, to an external
// combinational ALU and captures the ALU result one cycle later.
//
// Optional feature macro: ALU_SEQ_OPCHECK_EN
//   When defined, an opcode outside the supported set is rejected. The block
//   raises o_err and stays in WAIT_OP, and o_opcode is not changed. When the
//   macro is not defined, the o_err port does not exist and every opcode
//   value is accepted.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   i_sw         : switch bus, source of operands and opcode
//   i_btn_load   : debounced load button (level); only its rising edge counts
//   i_btn_clr    : abort button (level); returns to WAIT_A, clears o_valid
//   o_dato_a     : operand A to the ALU
//   o_dato_b     : operand B to the ALU
//   o_opcode     : opcode to the ALU
//   i_alu_out    : combinational ALU result
//   o_result     : captured ALU result
//   o_valid      : high while o_result holds a fresh result
//   o_state      : current state encoding (for LEDs)
//   o_err        : illegal-opcode flag (only with ALU_SEQ_OPCHECK_EN)
//
// state   | meaning
// --------+----------------------------------------------------------
// WAIT_A  | waiting for the load press that captures operand A
// WAIT_B  | waiting for the load press that captures operand B
// WAIT_OP | waiting for the load press that captures the opcode
// EXEC    | one cycle; ALU result is registered on this edge
// DONE    | result held; a load press starts a new sequence (as WAIT_A)
// ----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NB_DATA-1:0]   i_sw,
  input  logic                 i_btn_load,
  input  logic                 i_btn_clr,
  output logic [NB_DATA-1:0]   o_dato_a,
  output logic [NB_DATA-1:0]   o_dato_b,
  output logic [NB_OPCODE-1:0] o_opcode,
  input  logic [NB_DATA-1:0]   i_alu_out,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_valid,
  output logic [2:0]           o_state
`ifdef ALU_SEQ_OPCHECK_EN
  ,
  output logic                 o_err
`endif
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e               state_q,     state_d;
  logic [NB_DATA-1:0]   dato_a_q,    dato_a_d;
  logic [NB_DATA-1:0]   dato_b_q,    dato_b_d;
  logic [NB_OPCODE-1:0] opcode_q,    opcode_d;
  logic [NB_DATA-1:0]   result_q,    result_d;
  logic                 valid_q,     valid_d;
  logic                 load_prev_q, load_prev_d;
  logic                 load_evt;
  logic [NB_OPCODE-1:0] opcode_in;

`ifdef ALU_SEQ_OPCHECK_EN
  logic                 err_q, err_d;

  function automatic logic opcode_legal(input logic [NB_OPCODE-1:0] op);
    case (op)
      NB_OPCODE'(6'b100000),
      NB_OPCODE'(6'b100010),
      NB_OPCODE'(6'b100100),
      NB_OPCODE'(6'b100101),
      NB_OPCODE'(6'b100110),
      NB_OPCODE'(6'b000011),
      NB_OPCODE'(6'b000010),
      NB_OPCODE'(6'b100111): opcode_legal = 1'b1;
      default:               opcode_legal = 1'b0;
    endcase
  endfunction
`endif

  // Upper switch bits are simply dropped for the opcode.
  assign opcode_in = i_sw[NB_OPCODE-1:0];

  // The previous sample updates every cycle, whatever the state. A press
  // that lands in EXEC, or together with clear, is therefore used up and
  // not kept for later.
  assign load_evt  = i_btn_load & ~load_prev_q;

  always_comb begin
    state_d     = state_q;
    dato_a_d    = dato_a_q;
    dato_b_d    = dato_b_q;
    opcode_d    = opcode_q;
    result_d    = result_q;
    valid_d     = valid_q;
    load_prev_d = i_btn_load;
`ifdef ALU_SEQ_OPCHECK_EN
    err_d       = err_q;
`endif

    if (i_btn_clr) begin
      // Clear wins over a simultaneous load. Data registers keep their values.
      state_d = WAIT_A;
      valid_d = 1'b0;
`ifdef ALU_SEQ_OPCHECK_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        WAIT_A, DONE: begin
          if (load_evt) begin
            dato_a_d = i_sw;
            valid_d  = 1'b0;
            state_d  = WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_evt) begin
            dato_b_d = i_sw;
            state_d  = WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (load_evt) begin
`ifdef ALU_SEQ_OPCHECK_EN
            if (opcode_legal(opcode_in)) begin
              opcode_d = opcode_in;
              err_d    = 1'b0;
              state_d  = EXEC;
            end else begin
              err_d    = 1'b1;
            end
`else
            opcode_d = opcode_in;
            state_d  = EXEC;
`endif
          end
        end
        EXEC: begin
          result_d = i_alu_out;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_A;
      dato_a_q    <= '0;
      dato_b_q    <= '0;
      opcode_q    <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      // Reset to 1 so that a button held through reset does not count as a press.
      load_prev_q <= 1'b1;
`ifdef ALU_SEQ_OPCHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dato_a_q    <= dato_a_d;
      dato_b_q    <= dato_b_d;
      opcode_q    <= opcode_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      load_prev_q <= load_prev_d;
`ifdef ALU_SEQ_OPCHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign o_dato_a = dato_a_q;
  assign o_dato_b = dato_b_q;
  assign o_opcode = opcode_q;
  assign o_result = result_q;
  assign o_valid  = valid_q;
  assign o_state  = state_q;
`ifdef ALU_SEQ_OPCHECK_EN
  assign o_err    = err_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_sw;
  logic       i_btn_load;
  logic       i_btn_clr;
  logic [7:0] o_dato_a;
  logic [7:0] o_dato_b;
  logic [5:0] o_opcode;
  logic [7:0] i_alu_out;
  logic [7:0] o_result;
  logic       o_valid;
  logic [2:0] o_state;
`ifdef ALU_SEQ_OPCHECK_EN
  logic       o_err;
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  alu_sequencer #(.NB_DATA(8), .NB_OPCODE(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sw       (i_sw),
    .i_btn_load (i_btn_load),
    .i_btn_clr  (i_btn_clr),
    .o_dato_a   (o_dato_a),
    .o_dato_b   (o_dato_b),
    .o_opcode   (o_opcode),
    .i_alu_out  (i_alu_out),
    .o_result   (o_result),
    .o_valid    (o_valid),
    .o_state    (o_state)
`ifdef ALU_SEQ_OPCHECK_EN
    ,
    .o_err      (o_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      6'h27:   return ~(a | b);
      default: return a ^ 8'h5A;
    endcase
  endfunction

  assign i_alu_out = alu_fn(o_dato_a, o_dato_b, o_opcode);

  logic [5:0] legal_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: the step of the sequence reached (0..4), the captured
  // values, and the last button level seen.
  int         m_step;
  logic [7:0] m_a, m_b, m_res;
  logic [5:0] m_op;
  logic       m_valid, m_prev, m_err;

  task automatic model_edge(input logic btn, input logic clr, input logic [7:0] sw);
    bit press;
    if (!rst_n) begin
      m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0;
      m_valid = 0; m_err = 0; m_prev = 1;
      return;
    end
    press  = btn && !m_prev;
    m_prev = btn;
    if (clr) begin
      m_step = 0; m_valid = 0; m_err = 0;
    end else if (m_step == 3) begin
      m_res = alu_fn(m_a, m_b, m_op); m_valid = 1; m_step = 4;
    end else if (press) begin
      if (m_step == 0 || m_step == 4) begin
        m_a = sw; m_valid = 0; m_step = 1;
      end else if (m_step == 1) begin
        m_b = sw; m_step = 2;
      end else if (OPCHECK && !is_legal(sw[5:0])) begin
        m_err = 1;
      end else begin
        m_op = sw[5:0]; m_err = 0; m_step = 3;
      end
    end
  endtask

  task automatic tick(input logic btn, input logic clr, input logic [7:0] sw);
    i_btn_load = btn; i_btn_clr = clr; i_sw = sw;
    model_edge(btn, clr, sw);
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] sw);
    tick(1'b1, 1'b0, sw);
    tick(1'b0, 1'b0, sw);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(1'b1, 1'b1, 8'hFF);
    tick(1'b1, 1'b0, 8'hFF);
    rst_n = 1'b1;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    checks++; if ({o_dato_a, o_dato_b, o_opcode, o_result} !== 30'd0) begin errors++;
      $display("FAIL reset_data: got a=%h b=%h op=%h r=%h expected all 0", o_dato_a, o_dato_b, o_opcode, o_result); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
`ifdef ALU_SEQ_OPCHECK_EN
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
`endif
    // Button still high from reset: no press until it falls and rises again
    tick(1'b1, 1'b0, 8'h44);
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_held_btn: got state %0d expected 0", o_state); end
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_basic_add;
    tick(1'b0, 1'b1, 8'h00);
    load(8'h05);
    load(8'h03);
    tick(1'b1, 1'b0, 8'h20);
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL add_exec_state: got %0d expected 3", o_state); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL add_valid_early: got %b expected 0", o_valid); end
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL add_done_state: got %0d expected 4", o_state); end
    checks++; if (o_result !== 8'h08 || o_valid !== 1'b1) begin errors++;
      $display("FAIL add_result: got r=%h v=%b expected r=08 v=1", o_result, o_valid); end
    checks++; if (o_dato_a !== 8'h05 || o_dato_b !== 8'h03 || o_opcode !== 6'h20) begin errors++;
      $display("FAIL add_operands: got a=%h b=%h op=%h expected 05 03 20", o_dato_a, o_dato_b, o_opcode); end
  endtask

  task automatic test_back_to_back;
    tick(1'b0, 1'b0, 8'hEE);
    checks++; if (o_state !== 3'd4 || o_result !== 8'h08 || o_valid !== 1'b1 || o_dato_a !== 8'h05) begin errors++;
      $display("FAIL done_hold: got s=%0d r=%h v=%b a=%h expected 4 08 1 05", o_state, o_result, o_valid, o_dato_a); end
    tick(1'b1, 1'b0, 8'h10);
    checks++; if (o_state !== 3'd1 || o_dato_a !== 8'h10 || o_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_load: got s=%0d a=%h v=%b expected 1 10 0", o_state, o_dato_a, o_valid); end
    checks++; if (o_result !== 8'h08) begin errors++; $display("FAIL b2b_result_hold: got %h expected 08", o_result); end
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_held_button;
    tick(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 8'h7F);
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL held_state: got %0d expected 1", o_state); end
    checks++; if (o_dato_a !== 8'h7F) begin errors++; $display("FAIL held_a: got %h expected 7f", o_dato_a); end
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_clear_priority;
    logic [5:0] op_before;
    tick(1'b0, 1'b1, 8'h00);
    load(8'h44);
    load(8'h55);
    op_before = m_op;
    checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL clr_setup: got state %0d expected 2", o_state); end
    tick(1'b1, 1'b1, 8'h22);
    checks++; if (o_state !== 3'd0 || o_valid !== 1'b0) begin errors++;
      $display("FAIL clr_prio: got s=%0d v=%b expected 0 0", o_state, o_valid); end
    checks++; if (o_opcode !== op_before || o_dato_b !== 8'h55) begin errors++;
      $display("FAIL clr_hold: got op=%h b=%h expected %h 55", o_opcode, o_dato_b, op_before); end
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_sequence;
    tick(1'b0, 1'b1, 8'h00);
    load(8'h12);
    rst_n = 1'b0;
    tick(1'b1, 1'b0, 8'h99);
    rst_n = 1'b1;
    checks++; if (o_state !== 3'd0 || {o_dato_a, o_dato_b, o_opcode, o_result} !== 30'd0 || o_valid !== 1'b0) begin errors++;
      $display("FAIL rstmid_clear: got s=%0d a=%h b=%h op=%h r=%h v=%b expected all 0",
               o_state, o_dato_a, o_dato_b, o_opcode, o_result, o_valid); end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h99);
    checks++; if (o_state !== 3'd0 || o_dato_a !== 8'h00) begin errors++;
      $display("FAIL rstmid_no_event: got s=%0d a=%h expected 0 00", o_state, o_dato_a); end
    tick(1'b0, 1'b0, 8'h99);
    tick(1'b1, 1'b0, 8'h66);
    checks++; if (o_state !== 3'd1 || o_dato_a !== 8'h66) begin errors++;
      $display("FAIL rstmid_repress: got s=%0d a=%h expected 1 66", o_state, o_dato_a); end
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_opcode_check;
    tick(1'b0, 1'b1, 8'h00);
    load(8'h01);
    load(8'h02);
    tick(1'b1, 1'b0, 8'h3F);
`ifdef ALU_SEQ_OPCHECK_EN
    checks++; if (o_err !== 1'b1 || o_state !== 3'd2) begin errors++;
      $display("FAIL opchk_bad: got err=%b s=%0d expected 1 2", o_err, o_state); end
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h22);
    checks++; if (o_err !== 1'b0 || o_state !== 3'd3 || o_opcode !== 6'h22) begin errors++;
      $display("FAIL opchk_good: got err=%b s=%0d op=%h expected 0 3 22", o_err, o_state, o_opcode); end
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (o_result !== 8'hFF) begin errors++; $display("FAIL opchk_result: got %h expected ff", o_result); end
`else
    checks++; if (o_state !== 3'd3 || o_opcode !== 6'h3F) begin errors++;
      $display("FAIL opchk_accept: got s=%0d op=%h expected 3 3f", o_state, o_opcode); end
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (o_result !== (8'h01 ^ 8'h5A)) begin errors++; $display("FAIL opchk_result: got %h expected 5b", o_result); end
`endif
  endtask

  task automatic test_random;
    logic       btn, clr;
    logic [7:0] sw;
    for (int i = 0; i < 600; i++) begin
      btn = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 11) == 0);
      sw  = 8'($urandom);
      if (m_step == 2 && $urandom_range(0, 2) != 0)
        sw = {2'($urandom), legal_ops[$urandom_range(0, 7)]};
      rst_n = ($urandom_range(0, 60) != 0);
      tick(btn, clr, sw);
      rst_n = 1'b1;
      checks++; if (o_state !== 3'(m_step)) begin errors++;
        $display("FAIL rnd_state[%0d]: got %0d expected %0d", i, o_state, m_step); end
      checks++; if (o_dato_a !== m_a || o_dato_b !== m_b || o_opcode !== m_op) begin errors++;
        $display("FAIL rnd_operands[%0d]: got %h %h %h expected %h %h %h", i, o_dato_a, o_dato_b, o_opcode, m_a, m_b, m_op); end
      checks++; if (o_result !== m_res || o_valid !== m_valid) begin errors++;
        $display("FAIL rnd_result[%0d]: got r=%h v=%b expected r=%h v=%b", i, o_result, o_valid, m_res, m_valid); end
`ifdef ALU_SEQ_OPCHECK_EN
      checks++; if (o_err !== m_err) begin errors++;
        $display("FAIL rnd_err[%0d]: got %b expected %b", i, o_err, m_err); end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; i_btn_load = 1'b0; i_btn_clr = 1'b0; i_sw = 8'h00;
    test_reset;
    test_basic_add;
    test_back_to_back;
    test_held_button;
    test_clear_priority;
    test_reset_mid_sequence;
    test_opcode_check;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
